// File: rtl/cdce_lock_supervisor_if.sv
// Signal bundle between the CDCE62005 lock supervisor and its surroundings:
// the sequencing request, the config-engine handshake, the raw PLL_LOCK pin
// and the status/debug outputs. The master modport is the supervisor itself;
// the slave modport is whatever drives start/cfg_finish/pll_lock and
// consumes the status.
interface cdce_lock_supervisor_if;
    logic        start;       // single-cycle (re)start request
    logic        cfg_finish;  // config engine done flag, active low, clk domain
    logic        pll_lock;    // raw PLL_LOCK pin, asynchronous
    logic        cfg_en;      // config engine enable, 0 = engine held idle
    logic        locked;      // configured and debounced lock stable
    logic        fault;       // sticky, retries exhausted
    logic [3:0]  retry_cnt;   // retries in the current sequence
    logic [15:0] lol_cnt;     // loss-of-lock events since reset
    logic [2:0]  state_o;     // FSM state encoding for debug

    modport master (
        input  start,
        input  cfg_finish,
        input  pll_lock,
        output cfg_en,
        output locked,
        output fault,
        output retry_cnt,
        output lol_cnt,
        output state_o
    );

    modport slave (
        output start,
        output cfg_finish,
        output pll_lock,
        input  cfg_en,
        input  locked,
        input  fault,
        input  retry_cnt,
        input  lol_cnt,
        input  state_o
    );
endinterface

// File: rtl/cdce_lock_supervisor.sv
// Supervisor for the CDCE62005 configuration engine. Pulses the engine's
// enable low for a clean restart, waits for its active-low done flag, lets
// the PLL settle, then watches a synchronized and debounced PLL_LOCK. Any
// timeout, missing lock or loss of lock re-runs configuration until the
// retry budget is spent, after which a sticky fault is raised.
// All outputs come straight from flops; the Moore outputs are decoded from
// the next state so they line up with the state register.
module cdce_lock_supervisor #(
    parameter int unsigned EN_LOW_CYCLES = 64,
    parameter int unsigned CFG_TIMEOUT   = 1000000,
    parameter int unsigned SETTLE_CYCLES = 100000,
    parameter int unsigned DEBOUNCE      = 16,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    cdce_lock_supervisor_if.master        sup
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET_CFG = 3'd1,
        ST_WAIT_CFG  = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_LOCKED    = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    // Terminal counts of the shared timer (timer counts from 0 on state entry).
    localparam logic [31:0] EN_LOW_LAST  = 32'(EN_LOW_CYCLES - 1);
    localparam logic [31:0] CFG_LAST     = 32'(CFG_TIMEOUT - 1);
    localparam logic [31:0] SETTLE_LAST  = 32'(SETTLE_CYCLES - 1);
    localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRY);

    // Debounce counter only needs to reach DEBOUNCE-1.
    localparam int unsigned DBW          = $clog2(DEBOUNCE) + 1;
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE - 1);
    localparam logic [DBW-1:0] DB_ZERO   = {DBW{1'b0}};
    localparam logic [DBW-1:0] DB_ONE    = {{(DBW-1){1'b0}}, 1'b1};

    // PLL_LOCK synchronizer and debouncer
    logic           sync1_q;
    logic           sync2_q;
    logic           lock_db_q;
    logic           lock_db_d;
    logic [DBW-1:0] db_cnt_q;
    logic [DBW-1:0] db_cnt_d;

    // Sequencer
    state_t         state_q;
    state_t         state_d;
    logic [31:0]    timer_q;
    logic [31:0]    timer_d;
    logic [3:0]     retry_q;
    logic [3:0]     retry_d;
    logic [15:0]    lol_q;
    logic [15:0]    lol_d;
    logic           retry_go_s;
    logic           loss_s;

    // Registered outputs
    logic           cfg_en_q;
    logic           cfg_en_d;
    logic           locked_q;
    logic           locked_d;
    logic           fault_q;
    logic           fault_d;

    // Two-flop synchronizer bringing the asynchronous PLL_LOCK pin into clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sup.pll_lock;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: flip lock_db only after DEBOUNCE consecutive differing samples.
    always_comb begin
        lock_db_d = lock_db_q;
        db_cnt_d  = DB_ZERO;
        if (sync2_q != lock_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                lock_db_d = sync2_q;
                db_cnt_d  = DB_ZERO;
            end else begin
                db_cnt_d  = db_cnt_q + DB_ONE;
            end
        end else begin
            db_cnt_d = DB_ZERO;
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_db_q <= 1'b0;
            db_cnt_q  <= DB_ZERO;
        end else begin
            lock_db_q <= lock_db_d;
            db_cnt_q  <= db_cnt_d;
        end
    end

    // Next-state logic, retry bookkeeping and loss-of-lock counting.
    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        lol_d      = lol_q;
        retry_go_s = 1'b0;
        // A loss in LOCKED is a debounced lock drop or the engine dropping done.
        loss_s     = (!lock_db_q) || sup.cfg_finish;

        case (state_q)
            ST_IDLE: begin
                if (sup.start) begin
                    state_d = ST_RESET_CFG;
                    retry_d = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESET_CFG: begin
                if (timer_q == EN_LOW_LAST) begin
                    state_d = ST_WAIT_CFG;
                end else begin
                    state_d = ST_RESET_CFG;
                end
            end
            ST_WAIT_CFG: begin
                // Done flag beats a coincident timeout.
                if (!sup.cfg_finish) begin
                    state_d = ST_SETTLE;
                end else if (timer_q == CFG_LAST) begin
                    retry_go_s = 1'b1;
                end else begin
                    state_d = ST_WAIT_CFG;
                end
            end
            ST_SETTLE: begin
                if (timer_q == SETTLE_LAST) begin
                    if (lock_db_q) begin
                        state_d = ST_LOCKED;
                    end else begin
                        retry_go_s = 1'b1;
                    end
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_LOCKED: begin
                if (loss_s) begin
                    if (lol_q != 16'hFFFF) begin
                        lol_d = lol_q + 16'd1;
                    end else begin
                        lol_d = lol_q;
                    end
                end else begin
                    lol_d = lol_q;
                end
                // An explicit restart wins over the retry path but the loss
                // event above is still counted.
                if (sup.start) begin
                    state_d = ST_RESET_CFG;
                    retry_d = 4'd0;
                end else if (loss_s) begin
                    retry_go_s = 1'b1;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            ST_FAULT: begin
                if (sup.start) begin
                    state_d = ST_RESET_CFG;
                    retry_d = 4'd0;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                retry_d = 4'd0;
            end
        endcase

        // Retry path: decided in the same cycle the failure is seen.
        if (retry_go_s) begin
            if (retry_q < RETRY_LIMIT) begin
                retry_d = retry_q + 4'd1;
                state_d = ST_RESET_CFG;
            end else begin
                state_d = ST_FAULT;
            end
        end else begin
            retry_d = retry_d;
        end
    end

    // Shared timer: cleared on every state change, runs only in timed states.
    always_comb begin
        if (state_d != state_q) begin
            timer_d = 32'd0;
        end else if ((state_q == ST_RESET_CFG) || (state_q == ST_WAIT_CFG) ||
                     (state_q == ST_SETTLE)) begin
            timer_d = timer_q + 32'd1;
        end else begin
            timer_d = 32'd0;
        end
    end

    // Output decode from the next state so the registered outputs track state_q.
    always_comb begin
        case (state_d)
            ST_WAIT_CFG,
            ST_SETTLE: begin
                cfg_en_d = 1'b1;
                locked_d = 1'b0;
                fault_d  = 1'b0;
            end
            ST_LOCKED: begin
                cfg_en_d = 1'b1;
                locked_d = 1'b1;
                fault_d  = 1'b0;
            end
            ST_FAULT: begin
                cfg_en_d = 1'b0;
                locked_d = 1'b0;
                fault_d  = 1'b1;
            end
            default: begin
                cfg_en_d = 1'b0;
                locked_d = 1'b0;
                fault_d  = 1'b0;
            end
        endcase
    end

    // Sequencer state, timer, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            timer_q  <= 32'd0;
            retry_q  <= 4'd0;
            lol_q    <= 16'd0;
            cfg_en_q <= 1'b0;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            retry_q  <= retry_d;
            lol_q    <= lol_d;
            cfg_en_q <= cfg_en_d;
            locked_q <= locked_d;
            fault_q  <= fault_d;
        end
    end

    assign sup.cfg_en    = cfg_en_q;
    assign sup.locked    = locked_q;
    assign sup.fault     = fault_q;
    assign sup.retry_cnt = retry_q;
    assign sup.lol_cnt   = lol_q;
    assign sup.state_o   = state_q;

endmodule

// File: tb/tb_cdce_lock_supervisor.sv
// Directed bench for cdce_lock_supervisor with small timing parameters:
// EN_LOW=8, CFG_TIMEOUT=200, SETTLE=20, DEBOUNCE=4, MAX_RETRY=2.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_cdce_lock_supervisor;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RESET  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_LOCKED = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;

    cdce_lock_supervisor_if ifc ();

    cdce_lock_supervisor #(
        .EN_LOW_CYCLES (8),
        .CFG_TIMEOUT   (200),
        .SETTLE_CYCLES (20),
        .DEBOUNCE      (4),
        .MAX_RETRY     (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sup   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
        int k;
        k = 0;
        while ((ifc.state_o !== st) && (k < budget)) begin
            tick(1);
            k++;
        end
        chk(tag, {29'd0, ifc.state_o}, {29'd0, st});
    endtask

    initial begin
        n_checks       = 0;
        n_err          = 0;
        rst_n          = 1'b0;
        ifc.start      = 1'b0;
        ifc.cfg_finish = 1'b1;
        ifc.pll_lock   = 1'b0;
        tick(3);

        // Reset values
        chk("rst_cfg_en", {31'd0, ifc.cfg_en}, 32'd0);
        chk("rst_locked", {31'd0, ifc.locked}, 32'd0);
        chk("rst_fault",  {31'd0, ifc.fault},  32'd0);
        chk("rst_retry",  {28'd0, ifc.retry_cnt}, 32'd0);
        chk("rst_lol",    {16'd0, ifc.lol_cnt},   32'd0);
        chk("rst_state",  {29'd0, ifc.state_o},   32'd0);

        // Nominal: release at cycle 0, start in cycle 10
        rst_n        = 1'b1;
        ifc.pll_lock = 1'b1;
        tick(10);
        chk("idle_before_start", {29'd0, ifc.state_o}, {29'd0, S_IDLE});
        ifc.start = 1'b1;
        tick(1);                                              // cycle 11
        ifc.start = 1'b0;
        chk("nom_reset_cfg", {29'd0, ifc.state_o}, {29'd0, S_RESET});
        tick(7);                                              // cycle 18
        chk("nom_en_low_c18", {31'd0, ifc.cfg_en}, 32'd0);
        tick(1);                                              // cycle 19
        chk("nom_en_rise_c19", {31'd0, ifc.cfg_en}, 32'd1);
        chk("nom_wait_state", {29'd0, ifc.state_o}, {29'd0, S_WAIT});
        tick(49);                                             // cycle 68
        chk("nom_still_wait", {29'd0, ifc.state_o}, {29'd0, S_WAIT});
        ifc.cfg_finish = 1'b0;                                // seen at edge 69
        tick(1);                                              // cycle 69
        chk("nom_settle", {29'd0, ifc.state_o}, {29'd0, S_SETTLE});
        tick(19);                                             // cycle 88
        chk("nom_not_yet_locked", {31'd0, ifc.locked}, 32'd0);
        tick(1);                                              // cycle 89
        chk("nom_locked", {31'd0, ifc.locked}, 32'd1);
        chk("nom_retry0", {28'd0, ifc.retry_cnt}, 32'd0);
        chk("nom_fault0", {31'd0, ifc.fault}, 32'd0);

        // Glitch rejection: 3-cycle drop
        ifc.pll_lock = 1'b0;
        tick(3);
        ifc.pll_lock = 1'b1;
        tick(10);
        chk("glitch3_locked", {31'd0, ifc.locked}, 32'd1);
        chk("glitch3_lol",    {16'd0, ifc.lol_cnt}, 32'd0);

        // 10-cycle drop starting in cycle m
        ifc.pll_lock = 1'b0;
        tick(6);                                              // m+6
        chk("drop_m6_locked", {31'd0, ifc.locked}, 32'd1);
        tick(1);                                              // m+7
        chk("drop_lol1",     {16'd0, ifc.lol_cnt}, 32'd1);
        chk("drop_unlocked", {31'd0, ifc.locked}, 32'd0);
        chk("drop_reset",    {29'd0, ifc.state_o}, {29'd0, S_RESET});
        chk("drop_retry1",   {28'd0, ifc.retry_cnt}, 32'd1);
        chk("drop_cfg_en0",  {31'd0, ifc.cfg_en}, 32'd0);
        tick(3);                                              // m+10
        ifc.pll_lock = 1'b1;
        wait_state(S_LOCKED, 100, "relock_state");
        chk("relock_retry1", {28'd0, ifc.retry_cnt}, 32'd1);

        // cfg_finish returning high while LOCKED counts as loss; retry budget then hits the limit
        ifc.cfg_finish = 1'b1;                                // cycle p
        tick(1);                                              // p+1
        chk("cfgfin_lol2",   {16'd0, ifc.lol_cnt}, 32'd2);
        chk("cfgfin_retry2", {28'd0, ifc.retry_cnt}, 32'd2);
        chk("cfgfin_reset",  {29'd0, ifc.state_o}, {29'd0, S_RESET});
        tick(207);                                            // p+208
        chk("limit_wait_last", {29'd0, ifc.state_o}, {29'd0, S_WAIT});
        tick(1);                                              // p+209
        chk("limit_fault_state", {29'd0, ifc.state_o}, {29'd0, S_FAULT});
        chk("limit_fault", {31'd0, ifc.fault}, 32'd1);
        chk("limit_cfg_en0", {31'd0, ifc.cfg_en}, 32'd0);

        // Config timeout from a fresh start (cfg_finish held 1)
        ifc.start = 1'b1;                                     // cycle q
        tick(1);                                              // q+1
        ifc.start = 1'b0;
        chk("to_fault_cleared", {31'd0, ifc.fault}, 32'd0);
        chk("to_retry_cleared", {28'd0, ifc.retry_cnt}, 32'd0);
        chk("to_cfg_en0", {31'd0, ifc.cfg_en}, 32'd0);
        tick(207);                                            // q+208
        chk("to_wait1_last", {31'd0, ifc.cfg_en}, 32'd1);
        tick(1);                                              // q+209
        chk("to_retry1", {28'd0, ifc.retry_cnt}, 32'd1);
        chk("to_pulse2_low", {31'd0, ifc.cfg_en}, 32'd0);
        tick(7);                                              // q+216
        chk("to_pulse2_end", {31'd0, ifc.cfg_en}, 32'd0);
        tick(1);                                              // q+217
        chk("to_wait2_en", {31'd0, ifc.cfg_en}, 32'd1);
        tick(200);                                            // q+417
        chk("to_retry2", {28'd0, ifc.retry_cnt}, 32'd2);
        chk("to_pulse3_low", {31'd0, ifc.cfg_en}, 32'd0);
        tick(8);                                              // q+425
        chk("to_wait3_en", {31'd0, ifc.cfg_en}, 32'd1);
        tick(199);                                            // q+624
        chk("to_wait3_last", {29'd0, ifc.state_o}, {29'd0, S_WAIT});
        tick(1);                                              // q+625
        chk("to_fault_state", {29'd0, ifc.state_o}, {29'd0, S_FAULT});
        chk("to_fault", {31'd0, ifc.fault}, 32'd1);
        chk("to_cfg_en_off", {31'd0, ifc.cfg_en}, 32'd0);
        chk("to_not_locked", {31'd0, ifc.locked}, 32'd0);

        // No lock at settle
        ifc.pll_lock   = 1'b0;
        ifc.cfg_finish = 1'b0;
        tick(8);
        chk("nl_fault_hold", {29'd0, ifc.state_o}, {29'd0, S_FAULT});
        ifc.start = 1'b1;                                     // cycle r
        tick(1);                                              // r+1
        ifc.start = 1'b0;
        tick(28);                                             // r+29
        chk("nl_settle1", {29'd0, ifc.state_o}, {29'd0, S_SETTLE});
        tick(1);                                              // r+30
        chk("nl_retry1", {28'd0, ifc.retry_cnt}, 32'd1);
        chk("nl_reset1", {29'd0, ifc.state_o}, {29'd0, S_RESET});
        tick(29);                                             // r+59
        chk("nl_retry2", {28'd0, ifc.retry_cnt}, 32'd2);
        tick(28);                                             // r+87
        chk("nl_settle3", {29'd0, ifc.state_o}, {29'd0, S_SETTLE});
        tick(1);                                              // r+88
        chk("nl_fault", {31'd0, ifc.fault}, 32'd1);

        // Restart with lock present; a start pulse in SETTLE is ignored
        ifc.pll_lock = 1'b1;
        ifc.start    = 1'b1;                                  // cycle s
        tick(1);                                              // s+1
        ifc.start = 1'b0;
        chk("rs_fault_cleared", {31'd0, ifc.fault}, 32'd0);
        chk("rs_retry_cleared", {28'd0, ifc.retry_cnt}, 32'd0);
        tick(14);                                             // s+15
        chk("rs_settle", {29'd0, ifc.state_o}, {29'd0, S_SETTLE});
        ifc.start = 1'b1;
        tick(1);                                              // s+16
        ifc.start = 1'b0;
        chk("ign_start_settle", {29'd0, ifc.state_o}, {29'd0, S_SETTLE});
        tick(13);                                             // s+29
        chk("ign_not_yet", {31'd0, ifc.locked}, 32'd0);
        tick(1);                                              // s+30
        chk("ign_locked", {31'd0, ifc.locked}, 32'd1);
        chk("ign_no_fault", {31'd0, ifc.fault}, 32'd0);

        // start coinciding with debounced lock loss: start wins, loss still counted
        ifc.pll_lock = 1'b0;                                  // cycle m
        tick(6);                                              // m+6
        chk("co_still_locked", {31'd0, ifc.locked}, 32'd1);
        ifc.start = 1'b1;
        tick(1);                                              // m+7
        ifc.start      = 1'b0;
        ifc.pll_lock   = 1'b1;
        ifc.cfg_finish = 1'b1;
        chk("co_state", {29'd0, ifc.state_o}, {29'd0, S_RESET});
        chk("co_lol3",  {16'd0, ifc.lol_cnt}, 32'd3);
        chk("co_retry0", {28'd0, ifc.retry_cnt}, 32'd0);
        chk("co_unlocked", {31'd0, ifc.locked}, 32'd0);
        tick(8);                                              // m+15
        chk("co_wait", {29'd0, ifc.state_o}, {29'd0, S_WAIT});
        chk("co_cfg_en1", {31'd0, ifc.cfg_en}, 32'd1);

        // Asynchronous reset mid-WAIT_CFG, between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_cfg_en0", {31'd0, ifc.cfg_en}, 32'd0);
        chk("ar_state",   {29'd0, ifc.state_o}, 32'd0);
        chk("ar_lol0",    {16'd0, ifc.lol_cnt}, 32'd0);
        chk("ar_retry0",  {28'd0, ifc.retry_cnt}, 32'd0);
        chk("ar_locked0", {31'd0, ifc.locked}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(20);
        chk("post_rst_idle", {29'd0, ifc.state_o}, {29'd0, S_IDLE});
        chk("post_rst_cfg_en", {31'd0, ifc.cfg_en}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/cdce_lock_supervisor.md
Name: cdce_lock_supervisor

Overview:
- Supervises the CDCE62005 clock-chip configuration engine.
- Drives that engine's active-high `en` input and consumes its active-low `cfg_finish` done flag.
- After configuration, waits for the PLL to settle, then checks the chip's PLL_LOCK pin.
- Reports a stable `locked` status and retries configuration on timeout or loss of lock, up to a retry limit, after which it latches `fault`.

Parameters:
- EN_LOW_CYCLES, 64: cycles `cfg_en` is held low before each configuration attempt (clean restart of the config engine).
- CFG_TIMEOUT, 1000000: maximum cycles to wait for `cfg_finish` to go low after `cfg_en` rises.
- SETTLE_CYCLES, 100000: cycles waited after configuration completes before lock is evaluated.
- DEBOUNCE, 16: consecutive identical synchronized samples needed to change the debounced lock value.
- MAX_RETRY, 3: retries allowed after the first attempt before entering FAULT.

Ports:
- clk, input, 1: system clock; all logic on its rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: single-cycle request to (re)start the configuration sequence.
- cfg_finish, input, 1: from the config engine; 0 = configuration done; synchronous to clk.
- pll_lock, input, 1: CDCE62005 PLL_LOCK pin; asynchronous; 1 = locked.
- cfg_en, output, 1: to the config engine's `en`; 0 holds the engine in its idle/reset state.
- locked, output, 1: 1 = configuration done and debounced lock is stable.
- fault, output, 1: sticky; retries exhausted.
- retry_cnt, output, 4: retries performed in the current sequence; saturating.
- lol_cnt, output, 16: loss-of-lock events seen in LOCKED since reset; saturating at 16'hFFFF.
- state_o, output, 3: current state encoding, for debug.

Behaviour:
- Reset values: cfg_en=0, locked=0, fault=0, retry_cnt=0, lol_cnt=0, state IDLE, lock_db=0, all timers 0.
- Reset may assert in any state; it takes effect immediately and forces the reset values, so `cfg_en` drops at once.
- pll_lock synchronization and debounce:
  - Two-flop synchronizer into clk.
  - lock_db changes only after DEBOUNCE consecutive synchronized samples differ from its current value.
  - Net edge-to-lock_db latency is 2+DEBOUNCE cycles.
- cfg_finish is used directly, with no synchronizer.
- A single shared 32-bit timer clears on every state entry.
- States (state_o encodings):
  - IDLE (0): cfg_en=0. On start -> RESET_CFG.
  - RESET_CFG (1): cfg_en=0. When timer reaches EN_LOW_CYCLES-1 -> WAIT_CFG. cfg_en becomes 1 on the first WAIT_CFG cycle, i.e. exactly EN_LOW_CYCLES cycles after entering RESET_CFG.
  - WAIT_CFG (2): cfg_en=1.
    - cfg_finish==0 -> SETTLE.
    - Otherwise, timer reaching CFG_TIMEOUT-1 -> RETRY path.
    - If cfg_finish==0 in the timeout cycle, SETTLE wins.
  - SETTLE (3): cfg_en=1. When timer reaches SETTLE_CYCLES-1: lock_db==1 -> LOCKED, else -> RETRY path.
  - LOCKED (4): cfg_en=1, locked=1.
    - lock_db falling -> lol_cnt+1 (saturating), locked=0 next cycle, then RETRY path.
    - cfg_finish returning to 1 is also treated as loss of lock and counted in lol_cnt.
  - FAULT (5): cfg_en=0, fault=1, locked=0.
- RETRY path (decision made in the transition cycle):
  - retry_cnt < MAX_RETRY -> retry_cnt+1, -> RESET_CFG.
  - Otherwise -> FAULT.
- start handling:
  - Honoured only in IDLE, LOCKED and FAULT; ignored in RESET_CFG, WAIT_CFG and SETTLE.
  - In LOCKED or FAULT: clears retry_cnt and fault, sets locked=0, -> RESET_CFG. lol_cnt is not cleared.
  - If start and lock_db falling coincide in LOCKED, start wins and lol_cnt still increments.
- locked and fault are never 1 at the same time.

Test Plan:
Bench parameters for all scenarios: EN_LOW=8, CFG_TIMEOUT=200, SETTLE=20, DEBOUNCE=4, MAX_RETRY=2.
- Nominal: start at cycle 10, cfg_finish driven low 50 cycles after cfg_en rises, pll_lock=1 -> cfg_en rises at cycle 19; locked=1 exactly 20 cycles after cfg_finish falls; retry_cnt=0, fault=0.
- Config timeout: cfg_finish held 1 -> three cfg_en low pulses of 8 cycles each; retry_cnt goes 1 then 2; FAULT entered 200 cycles into the third WAIT_CFG; fault=1, cfg_en=0.
- Glitch rejection: while LOCKED, drop pll_lock for 3 cycles -> locked stays 1, lol_cnt=0. Drop it for 10 cycles -> lol_cnt=1, locked=0, RESET_CFG entered, retry_cnt=1.
- No lock at settle: cfg_finish=0 but pll_lock=0 -> each SETTLE ends in retry; FAULT after retry_cnt=2. A subsequent start clears fault and retry_cnt; with pll_lock=1 the bench reaches locked=1.
- Reset mid-sequence: assert rst_n=0 during WAIT_CFG -> cfg_en=0 in the same cycle with no clock edge needed; all outputs at reset values. After release, no activity until start.
- Ignored start: pulse start during SETTLE -> no restart; sequence completes to LOCKED on schedule.
